clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel programmable clock divider. From the board clock `clk_in` it generates `N_CH` independent divided outputs. Each channel provides a near-50 % square wave for LEDs and display-multiplex logic, and a one-cycle `tick` strobe for clock-enable use inside the `clk_in` domain. Divisors can be reprogrammed at runtime through a write port. Changes apply glitch-free at the channel's period boundary. A common `sync` input realigns all channels.

## Interface
- `N_CH`, 2, number of channels (1..8)
- `DIV_W`, 28, divisor/counter width per channel
- `RESET_DIV`, 134217728, divisor loaded into every channel on reset (0 = channel disabled)
- `CH_W`, $clog2(N_CH) with minimum 1, width of `cfg_ch`
- `clk_in`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  reset, synchronous, active-high
- `cfg_we`  in  1  one-cycle write strobe for a divisor
- `cfg_ch`  in  CH_W  target channel of the write
- `cfg_div`  in  DIV_W  new divisor D (period in `clk_in` cycles; 0 = disable)
- `sync`  in  1  one-cycle strobe restarting all channels at phase 0
- `clk_out`  out  N_CH  divided square wave per channel
- `tick`  out  N_CH  one-cycle strobe per channel, once per period
- `pending`  out  N_CH  a written divisor is waiting for the period boundary

## Operation
- Per channel state:
  - active divisor `D`
  - shadow divisor `S`
  - pending flag
  - counter `cnt` (DIV_W bits, 0..D-1)
- On reset, per channel: `D=S=RESET_DIV`, `cnt=0`, `pending=0`. `clk_out`, `tick` and `pending` are all 0 while `reset` is high.
- Enabled channel (D ≥ 1), counting:
  - `cnt` advances by 1 each cycle and wraps from D-1 to 0.
  - `tick=1` exactly in cycles with `cnt==D-1`.
  - `clk_out=1` while `cnt < ceil(D/2)`, else 0.
  - D=1: `tick` and `clk_out` are held high constantly.
- Disabled channel (D=0): `cnt` held at 0; `clk_out=0`, `tick=0`.
- Write: `cfg_we` with `cfg_ch < N_CH` sets `S=cfg_div` and `pending=1` on that channel.
  - `cfg_ch ≥ N_CH`: the write is ignored.
  - A second write before the boundary overwrites `S`; the last write wins.
- Apply rule:
  - A pending `S` is copied to `D` at the wrap edge (the edge leaving `cnt==D-1`).
  - The new period starts with `cnt=0`; `pending` clears on the same edge.
  - If the channel is disabled, `S` is applied on the edge following the write.
  - A current period is never truncated or extended, so there are no runt pulses.
- `sync`:
  - On the next edge, every channel applies any pending `S` immediately and sets `cnt=0`; all `pending` clear.
  - Same-cycle `cfg_we` and `sync`: the written value goes to `S`, is applied by that same sync edge, and `pending` ends 0.
- Same-cycle write and wrap on the target channel: the new value is applied at that wrap edge.
- Reset mid-operation overrides everything, including pending writes and `sync`. State returns to reset values on that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Edge 1 is the first rising edge with `reset` low. For a channel with D ≥ 1:
  - `clk_out` is high in cycles 1..ceil(D/2) and low for the following floor(D/2) cycles, then repeats with period D.
  - `tick` is high in cycle D, then in cycles 2D, 3D, …
- Write latency:
  - `pending` rises in the cycle after the `cfg_we` edge.
  - The new divisor takes effect at the first wrap at or after that edge.
- `sync` latency: `cnt=0` in the cycle after the `sync` edge, so every enabled channel is in its first high phase simultaneously.
- The counter never exceeds D-1. D = 2^DIV_W - 1 is legal.

## Test plan
- Reset defaults (RESET_DIV=4, N_CH=2), release `reset`: both `clk_out` follow 1,1,0,0 repeating; `tick` is high in cycles 4, 8, 12. During reset, all outputs are 0.
- Duty cases via writes to ch0 then `sync`:
  - D=1 → `clk_out`/`tick` constant 1.
  - D=2 → 1,0.
  - D=3 → 1,1,0 with `tick` in the third cycle.
  - D=0 → both 0, `cnt` frozen.
- Runtime change: ch0 at D=8, write D=2 when `cnt==3`. Then:
  - `pending[0]=1` for 4 more cycles, and the 8-cycle period completes unchanged.
  - Next cycle `cnt=0` and the period is 2; ch1 is unaffected.
- Last-write-wins plus out-of-range: write ch1 D=5, then D=6, then `cfg_ch=3` (N_CH=2) with D=9. Ch1 applies 6; no channel changes to 9.
- `sync` with simultaneous write: ch0 D=6, ch1 D=10 at arbitrary phases; pulse `sync` together with a write ch1 D=4. Next cycle both `cnt=0`, ch1 period is 4, `pending=0`.
- Reset mid-operation: with a write pending, assert `reset` for 1 cycle. `pending` clears, D returns to RESET_DIV, and the waveform restarts as in the first scenario.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel square wave and tick strobe,
// runtime divisor writes applied at the period boundary, common sync realignment.
module clk_div_multi #(
    parameter int          N_CH      = 2,
    parameter int          DIV_W     = 28,
    parameter int unsigned RESET_DIV = 134217728,
    parameter int          CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync,
    output logic [N_CH-1:0]   clk_out,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending
);

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(RESET_DIV);

    // ceil(d/2) without widening: floor(d/2) plus the dropped bit
    function automatic logic [DIV_W-1:0] half_up(input logic [DIV_W-1:0] d);
        return (d >> 1) + {{(DIV_W-1){1'b0}}, d[0]};
    endfunction

    // Low only on the first edge after reset, so that edge presents phase 0 instead of advancing
    logic run_q;

    always_ff @(posedge clk_in) begin
        if (reset)
            run_q <= 1'b0;
        else
            run_q <= 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_q, shd_q, cnt_q;
        logic             pend_q, clk_q, tick_q;
        logic             wr, wrap, take, pend_n;
        logic [DIV_W-1:0] shd_n, div_n, cnt_n;

        // Outputs are registered from the next-state phase, so they line up with cnt_q
        always_comb begin
            wr     = cfg_we && (cfg_ch == CH_W'(i));
            shd_n  = wr ? cfg_div : shd_q;
            pend_n = wr || pend_q;
            wrap   = run_q && (div_q != '0) && (cnt_q == div_q - 1'b1);
            take   = sync || wrap || ((div_q == '0) && pend_q);
            div_n  = (take && pend_n) ? shd_n : div_q;
            cnt_n  = (take || !run_q || (div_n == '0)) ? '0 : cnt_q + 1'b1;
        end

        always_ff @(posedge clk_in) begin
            if (reset) begin
                div_q  <= DIV_RST;
                shd_q  <= DIV_RST;
                cnt_q  <= '0;
                pend_q <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_n;
                shd_q  <= shd_n;
                cnt_q  <= cnt_n;
                pend_q <= pend_n && !take;
                clk_q  <= (div_n != '0) && (cnt_n < half_up(div_n));
                tick_q <= (div_n != '0) && (cnt_n == div_n - 1'b1);
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign pending[i] = pend_q;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: reset pattern, duty cases, runtime writes, sync and mid-run reset.
module tb_clk_div_multi;

    localparam int N_CH  = 2;
    localparam int DIV_W = 8;
    localparam int CH_W  = 2;

    logic              clk_in = 1'b0;
    logic              reset  = 1'b1;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              sync   = 1'b0;
    logic [N_CH-1:0]   clk_out, tick, pending;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    clk_div_multi #(
        .N_CH(N_CH), .DIV_W(DIV_W), .RESET_DIV(4), .CH_W(CH_W)
    ) dut (
        .clk_in(clk_in), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .sync(sync), .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    function automatic logic exp_clk(input int d, input int ph);
        return (d != 0) && (ph < (d + 1) / 2);
    endfunction

    function automatic logic exp_tick(input int d, input int ph);
        return (d != 0) && (ph == d - 1);
    endfunction

    // Expected {pending, tick, clk_out} for both channels
    function automatic logic [5:0] expv(input int d0, input int p0, input int d1, input int p1,
                                        input logic [1:0] pend);
        return {pend, exp_tick(d1, p1), exp_tick(d0, p0), exp_clk(d1, p1), exp_clk(d0, p0)};
    endfunction

    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic write(input int ch, input int d);
        cfg_we  = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = DIV_W'(d);
    endtask

    task automatic test_reset();
        logic [5:0] e;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_cmp++;
            if ({pending, tick, clk_out} !== 6'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc %0d got %b exp %b", k, {pending, tick, clk_out}, 6'b0);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            e = expv(4, (k - 1) % 4, 4, (k - 1) % 4, 2'b00);
            n_cmp++;
            if ({pending, tick, clk_out} !== e) begin
                n_err++;
                $display("FAIL reset_release cyc %0d got %b exp %b", k, {pending, tick, clk_out}, e);
            end
        end
    endtask

    task automatic test_duty();
        int dl [5] = '{1, 2, 3, 255, 0};
        int n;
        logic [5:0] e;
        foreach (dl[j]) begin
            write(0, dl[j]);
            cyc();
            cfg_we = 1'b0;
            sync   = 1'b1;
            n = (dl[j] > 4) ? dl[j] + 2 : 8;
            for (int k = 1; k <= n; k++) begin
                cyc();
                sync = 1'b0;
                e = expv(dl[j], (dl[j] == 0) ? 0 : (k - 1) % dl[j], 4, (k - 1) % 4, 2'b00);
                n_cmp++;
                if ({pending, tick, clk_out} !== e) begin
                    n_err++;
                    $display("FAIL duty_d%0d cyc %0d got %b exp %b", dl[j], k, {pending, tick, clk_out}, e);
                end
            end
        end
    endtask

    task automatic test_runtime_change();
        logic [5:0] e;
        write(0, 8);
        cyc();
        cfg_we = 1'b0;
        sync   = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            sync   = 1'b0;
            cfg_we = 1'b0;
            if (k <= 8)
                e = expv(8, k - 1, 4, (k - 1) % 4, (k >= 5) ? 2'b01 : 2'b00);
            else
                e = expv(2, (k - 9) % 2, 4, (k - 1) % 4, 2'b00);
            n_cmp++;
            if ({pending, tick, clk_out} !== e) begin
                n_err++;
                $display("FAIL runtime_change cyc %0d got %b exp %b", k, {pending, tick, clk_out}, e);
            end
            if (k == 4) write(0, 2);
        end
    endtask

    task automatic test_last_write_wins();
        logic [5:0] e;
        sync = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            sync   = 1'b0;
            cfg_we = 1'b0;
            if (k <= 4)
                e = expv(2, (k - 1) % 2, 4, k - 1, (k >= 2) ? 2'b10 : 2'b00);
            else
                e = expv(2, (k - 1) % 2, 6, (k - 5) % 6, 2'b00);
            n_cmp++;
            if ({pending, tick, clk_out} !== e) begin
                n_err++;
                $display("FAIL last_write cyc %0d got %b exp %b", k, {pending, tick, clk_out}, e);
            end
            case (k)
                1: write(1, 5);
                2: write(1, 6);
                3: write(3, 9);
                default: ;
            endcase
        end
    endtask

    task automatic test_sync_write();
        logic [5:0] e;
        write(0, 6);
        cyc();
        write(1, 10);
        cyc();
        cfg_we = 1'b0;
        repeat (5) cyc();
        write(1, 4);
        sync = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            sync   = 1'b0;
            cfg_we = 1'b0;
            e = expv(6, (k - 1) % 6, 4, (k - 1) % 4, 2'b00);
            n_cmp++;
            if ({pending, tick, clk_out} !== e) begin
                n_err++;
                $display("FAIL sync_write cyc %0d got %b exp %b", k, {pending, tick, clk_out}, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] e;
        cyc();
        write(0, 3);
        cyc();
        cfg_we = 1'b0;
        e = expv(6, 1, 4, 1, 2'b01);
        n_cmp++;
        if ({pending, tick, clk_out} !== e) begin
            n_err++;
            $display("FAIL reset_mid_pending got %b exp %b", {pending, tick, clk_out}, e);
        end
        reset = 1'b1;
        sync  = 1'b1;
        write(1, 7);
        cyc();
        n_cmp++;
        if ({pending, tick, clk_out} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_mid_hold got %b exp %b", {pending, tick, clk_out}, 6'b0);
        end
        reset  = 1'b0;
        sync   = 1'b0;
        cfg_we = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            e = expv(4, (k - 1) % 4, 4, (k - 1) % 4, 2'b00);
            n_cmp++;
            if ({pending, tick, clk_out} !== e) begin
                n_err++;
                $display("FAIL reset_mid_restart cyc %0d got %b exp %b", k, {pending, tick, clk_out}, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_duty();
        test_runtime_change();
        test_last_write_wins();
        test_sync_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
